spi_uart_arbiter: RTL

Serial-output stage between the SPI capture path and the UART transmitter: merges sniffed SPI bytes (from `spi_device`) and command-parser replies (from `user_command_parser`) into one byte stream for `uart_tx_fifo`. SPI traffic is buffered in a small FIFO and SLIP-framed, one frame per chip-select transaction, so the host can split the stream into transactions. Parser bytes pass through unframed, only between SPI frames. SPI data has priority; dropped SPI bytes are counted.

---
 rtl/spi_uart_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_uart_arbiter.sv
// spi_uart_arbiter
// Merges sniffed SPI bytes and command-parser replies into one UART byte
// stream. SPI bytes are buffered in a FIFO and SLIP-framed: each chip-select
// transaction ends with a C0 delimiter, and C0/DB data bytes are escaped as
// DB DC / DB DD. Parser bytes go out unframed, only while no SPI frame is open
// or waiting to drain. SPI traffic has priority; SPI bytes lost to a full FIFO
// are counted in a saturating counter.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_cs              raw chip-select (active low, asynchronous to clk)
//   spi_rx_strobe/data  one-cycle pulse with a received SPI byte
//   user_txd_data/strobe/ready  single-byte parser buffer (ready = buffer empty)
//   uart_txd/strobe     registered byte + one-cycle pulse to the UART
//   uart_txd_ready      UART can take a byte
//   drop_count          saturating count of dropped SPI bytes
//   dbg_state_o         encoder FSM state (0 = IDLE, 1 = ESC)
//
// Handshakes: the UART side is strobe/ready; a byte is issued only when
// uart_txd_ready is high and no byte was issued the cycle before (the UART
// ready is registered, so it lags one cycle). The parser side may strobe only
// while user_txd_ready is high; a strobe while full overwrites the buffer.

module spi_uart_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_cs,
  input  logic                 spi_rx_strobe,
  input  logic [7:0]           spi_rx_data,
  input  logic [7:0]           user_txd_data,
  input  logic                 user_txd_strobe,
  output logic                 user_txd_ready,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  output logic [DROP_BITS-1:0] drop_count,
  output logic                 dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_ESC = 1'b1} state_e;

  // Chip-select synchronizer and rising-edge (deselect) detector
  logic cs_sync1_q, cs_sync2_q, cs_prev_q;
  logic deselect;

  // Framing state
  logic frame_active_q, frame_active_d;
  logic marker_pending_q, marker_pending_d;

  // FIFO of {marker, byte}
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;
  logic [8:0]  head;
  logic        data_push, marker_push, push, pop, drop;
  logic [8:0]  push_entry;

  // User buffer
  logic [7:0] user_buf_q;
  logic       user_pending_q;
  logic       user_send;

  // Encoder
  state_e     state_q;
  logic [7:0] esc_byte_q;
  logic [7:0] uart_txd_q;
  logic       uart_strobe_q;
  logic       send_ok;

  logic [DROP_BITS-1:0] drop_q;

  assign deselect   = cs_sync2_q && !cs_prev_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign send_ok    = uart_txd_ready && !uart_strobe_q;
  assign pop        = (state_q == ST_IDLE) && send_ok && !fifo_empty;
  // Parser bytes only go out between frames: nothing buffered, no frame open,
  // no delimiter still waiting for FIFO space.
  assign user_send  = (state_q == ST_IDLE) && send_ok && fifo_empty &&
                      user_pending_q && !frame_active_q && !marker_pending_q;

  // A simultaneous pop frees a slot, so a full FIFO can still accept data.
  assign data_push   = spi_rx_strobe && (!fifo_full || pop);
  assign drop        = spi_rx_strobe && !data_push;
  // The delimiter waits for a cycle with no data push and a free slot.
  assign marker_push = marker_pending_q && !data_push && !fifo_full;
  assign push        = data_push || marker_push;
  assign push_entry  = data_push ? {1'b0, spi_rx_data} : {1'b1, 8'h00};

  always_comb begin
    frame_active_d   = frame_active_q;
    marker_pending_d = marker_pending_q;
    if (marker_push) marker_pending_d = 1'b0;
    // A strobe coinciding with deselect belongs to the closing frame.
    if (deselect && (frame_active_q || spi_rx_strobe)) marker_pending_d = 1'b1;
    if (deselect)           frame_active_d = 1'b0;
    else if (spi_rx_strobe) frame_active_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync1_q       <= 1'b1;
      cs_sync2_q       <= 1'b1;
      cs_prev_q        <= 1'b1;
      frame_active_q   <= 1'b0;
      marker_pending_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      drop_q           <= '0;
      user_buf_q       <= 8'h00;
      user_pending_q   <= 1'b0;
    end else begin
      cs_sync1_q       <= spi_cs;
      cs_sync2_q       <= cs_sync1_q;
      cs_prev_q        <= cs_sync2_q;
      frame_active_q   <= frame_active_d;
      marker_pending_q <= marker_pending_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (drop_q != {DROP_BITS{1'b1}})) drop_q <= drop_q + 1'b1;
      if (user_txd_strobe) begin
        user_buf_q     <= user_txd_data;
        user_pending_q <= 1'b1;
      end else if (user_send) begin
        user_pending_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      esc_byte_q    <= 8'h00;
      uart_txd_q    <= 8'h00;
      uart_strobe_q <= 1'b0;
    end else begin
      uart_strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            uart_strobe_q <= 1'b1;
            if (head[8]) begin
              uart_txd_q <= 8'hC0;
            end else if (head[7:0] == 8'hC0) begin
              uart_txd_q <= 8'hDB;
              esc_byte_q <= 8'hDC;
              state_q    <= ST_ESC;
            end else if (head[7:0] == 8'hDB) begin
              uart_txd_q <= 8'hDB;
              esc_byte_q <= 8'hDD;
              state_q    <= ST_ESC;
            end else begin
              uart_txd_q <= head[7:0];
            end
          end else if (user_send) begin
            uart_strobe_q <= 1'b1;
            uart_txd_q    <= user_buf_q;
          end
        end
        ST_ESC: begin
          if (send_ok) begin
            uart_strobe_q <= 1'b1;
            uart_txd_q    <= esc_byte_q;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uart_txd        = uart_txd_q;
  assign uart_txd_strobe = uart_strobe_q;
  assign user_txd_ready  = !user_pending_q;
  assign drop_count      = drop_q;
  assign dbg_state_o     = state_q;

endmodule
